prod_accum: RTL and testbench

//   Downstream consumer of the multiplier result stream (out/valid_out, 16-bit products).

---
 rtl/prod_accum_pkg.sv | 36 +++
 rtl/prod_accum_if.sv | 33 +++
 rtl/prod_accum.sv | 138 +++++++++++++
 tb/tb_prod_accum.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prod_accum_pkg.sv
// rtl/prod_accum_pkg.sv - shared types and saturating adder for prod_accum
// Contents:
//   pa_state_e     FSM state encoding (IDLE, ACCUM, HOLD)
//   ACC_MAX_WIDTH  widest accumulator the adder helper supports
//   sat_add()      unsigned add clamped to an all-ones value of a given width
package prod_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pa_state_e;

  localparam int unsigned ACC_MAX_WIDTH = 32;

  // Returns {carry, sum}. Operands are zero-extended accumulator-width values;
  // when their true sum exceeds 2**width-1 the sum clamps to all-ones of that
  // width and the carry bit reports the saturation.
  function automatic logic [ACC_MAX_WIDTH:0] sat_add(
    input logic [ACC_MAX_WIDTH-1:0] a,
    input logic [ACC_MAX_WIDTH-1:0] b,
    input int unsigned              width
  );
    logic [ACC_MAX_WIDTH:0] one;
    logic [ACC_MAX_WIDTH:0] max_val;
    logic [ACC_MAX_WIDTH:0] full;
    one     = {{ACC_MAX_WIDTH{1'b0}}, 1'b1};
    max_val = (one << width) - one;
    full    = {1'b0, a} + {1'b0, b};
    if (full > max_val) begin
      return {1'b1, max_val[ACC_MAX_WIDTH-1:0]};
    end
    return {1'b0, full[ACC_MAX_WIDTH-1:0]};
  endfunction

endpackage

// File: rtl/prod_accum_if.sv
// rtl/prod_accum_if.sv - product-in / sum-out handshake bundle for prod_accum
// Signals:
//   in_valid, in_data, in_ready         product beats toward the accumulator
//   sum_valid, sum_data, sum_ovf,
//   sum_ready                           completed sums from the accumulator
// Modports:
//   slave   the accumulator side
//   master  the producer / consumer environment side
interface prod_accum_if #(
  parameter int RESULT_WIDTH = 16,
  parameter int ACC_WIDTH    = 24
);

  logic                    in_valid;
  logic [RESULT_WIDTH-1:0] in_data;
  logic                    in_ready;

  logic                    sum_valid;
  logic [ACC_WIDTH-1:0]    sum_data;
  logic                    sum_ovf;
  logic                    sum_ready;

  modport master (
    output in_valid, in_data, sum_ready,
    input  in_ready, sum_valid, sum_data, sum_ovf
  );

  modport slave (
    input  in_valid, in_data, sum_ready,
    output in_ready, sum_valid, sum_data, sum_ovf
  );

endinterface

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - sums BLOCK_LEN products into one saturating total
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   clear        synchronous flush of partial sum and any pending output
//   bus (slave)  in_valid/in_data/in_ready product beats in;
//                sum_valid/sum_data/sum_ovf/sum_ready completed sums out
//   blocks_done  count of sums handed off, wraps 0xFFFF -> 0
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int  RESULT_WIDTH = 16,
  parameter int  ACC_WIDTH    = 24,
  parameter int  BLOCK_LEN    = 4,
  localparam int CNT_WIDTH    = $clog2(BLOCK_LEN + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  prod_accum_if.slave  bus,
  output logic [15:0]  blocks_done
);

  if (ACC_WIDTH < RESULT_WIDTH) begin : g_chk_width
    $error("prod_accum: ACC_WIDTH must be >= RESULT_WIDTH");
  end
  if (ACC_WIDTH > ACC_MAX_WIDTH) begin : g_chk_max_width
    $error("prod_accum: ACC_WIDTH exceeds the sat_add helper width");
  end
  if (BLOCK_LEN < 1 || BLOCK_LEN > 255) begin : g_chk_len
    $error("prod_accum: BLOCK_LEN must be in 1..255");
  end

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BLOCK_LEN);

  pa_state_e               state;
  logic [ACC_WIDTH-1:0]    acc;
  logic [CNT_WIDTH-1:0]    cnt;
  logic                    ovf;

  logic                    beat;
  logic [ACC_MAX_WIDTH:0]  add_res;
  logic [ACC_WIDTH-1:0]    acc_sum;
  logic                    sum_carry;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic [ACC_WIDTH-1:0]    in_ext;

  // in_ready is a registered copy of (state != HOLD), so the beat qualifier
  // never depends combinationally on anything downstream.
  assign beat = bus.in_valid & bus.in_ready;

  always_comb begin
    add_res   = sat_add(ACC_MAX_WIDTH'(acc), ACC_MAX_WIDTH'(bus.in_data), ACC_WIDTH);
    acc_sum   = ACC_WIDTH'(add_res);
    sum_carry = add_res[ACC_MAX_WIDTH];
    cnt_inc   = cnt + CNT_WIDTH'(1);
    in_ext    = ACC_WIDTH'(bus.in_data);
  end

  // sum_data/sum_ovf are loaded with the same next-state values as acc/ovf on
  // the closing beat and zeroed on hand-off, so they read 0 outside HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.sum_valid <= 1'b0;
      bus.sum_data  <= '0;
      bus.sum_ovf   <= 1'b0;
      blocks_done   <= '0;
    end else if (clear) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.sum_valid <= 1'b0;
      bus.sum_data  <= '0;
      bus.sum_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            acc <= in_ext;
            cnt <= CNT_WIDTH'(1);
            ovf <= 1'b0;
            if (BLOCK_LEN == 1) begin
              state         <= HOLD;
              bus.in_ready  <= 1'b0;
              bus.sum_valid <= 1'b1;
              bus.sum_data  <= in_ext;
              bus.sum_ovf   <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end

        ACCUM: begin
          if (beat) begin
            acc <= acc_sum;
            cnt <= cnt_inc;
            ovf <= ovf | sum_carry;
            if (cnt_inc == LAST_CNT) begin
              state         <= HOLD;
              bus.in_ready  <= 1'b0;
              bus.sum_valid <= 1'b1;
              bus.sum_data  <= acc_sum;
              bus.sum_ovf   <= ovf | sum_carry;
            end
          end
        end

        HOLD: begin
          if (bus.sum_ready) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.sum_valid <= 1'b0;
            bus.sum_data  <= '0;
            bus.sum_ovf   <= 1'b0;
            blocks_done   <= blocks_done + 16'd1;
          end
        end

        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.sum_valid <= 1'b0;
          bus.sum_data  <= '0;
          bus.sum_ovf   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - self-checking bench for prod_accum
module tb_prod_accum;
  import prod_accum_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear0, clear17, clear1;
  logic [15:0] done0, done17, done1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_done0 = 0;
  int exp_done17 = 0;

  localparam logic [16:0] MAX17 = 17'h1FFFF;

  prod_accum_if #(.RESULT_WIDTH(16), .ACC_WIDTH(24)) bus0 ();
  prod_accum_if #(.RESULT_WIDTH(16), .ACC_WIDTH(17)) bus17 ();
  prod_accum_if #(.RESULT_WIDTH(16), .ACC_WIDTH(24)) bus1 ();

  prod_accum #(.RESULT_WIDTH(16), .ACC_WIDTH(24), .BLOCK_LEN(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0), .bus(bus0), .blocks_done(done0));
  prod_accum #(.RESULT_WIDTH(16), .ACC_WIDTH(17), .BLOCK_LEN(4)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .clear(clear17), .bus(bus17), .blocks_done(done17));
  prod_accum #(.RESULT_WIDTH(16), .ACC_WIDTH(24), .BLOCK_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .bus(bus1), .blocks_done(done1));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0][15:0] v;
    int               gap;
    int               stall;
    logic [23:0]      es;
    logic             eo;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic beat0(input logic [15:0] v, input int gap);
    int t;
    t = 0;
    while (!bus0.in_ready && t < 20) begin
      tick();
      t++;
    end
    chk("in_ready0_before_beat", bus0.in_ready, 1);
    bus0.in_valid = 1'b1;
    bus0.in_data  = v;
    tick();
    bus0.in_valid = 1'b0;
    bus0.in_data  = '0;
    repeat (gap) tick();
  endtask

  task automatic send0(input string name, input logic [3:0][15:0] v, input int gap,
                       input int stall, input logic [23:0] es, input logic eo);
    for (int i = 0; i < 4; i++) begin
      beat0(v[i], (i == 3) ? 0 : gap);
      if (i == 2) chk({name, "_early_valid"}, bus0.sum_valid, 0);
    end
    chk({name, "_latency_valid"}, bus0.sum_valid, 1);
    chk({name, "_sum"}, bus0.sum_data, es);
    chk({name, "_ovf"}, bus0.sum_ovf, eo);
    if (stall > 0) begin
      bus0.sum_ready = 1'b0;
      bus0.in_valid  = 1'b1;
      bus0.in_data   = 16'd1000;
      for (int k = 0; k < stall; k++) begin
        tick();
        chk({name, "_stall_valid"}, bus0.sum_valid, 1);
        chk({name, "_stall_sum"}, bus0.sum_data, es);
        chk({name, "_stall_in_ready"}, bus0.in_ready, 0);
      end
      bus0.sum_ready = 1'b1;
      bus0.in_valid  = 1'b0;
      bus0.in_data   = '0;
    end
    tick();
    exp_done0++;
    chk({name, "_blocks_done"}, done0, exp_done0[15:0]);
    chk({name, "_valid_after"}, bus0.sum_valid, 0);
    chk({name, "_sum_zero_after"}, bus0.sum_data, 0);
    chk({name, "_in_ready_after"}, bus0.in_ready, 1);
  endtask

  task automatic send17(input string name, input logic [3:0][15:0] v, input int gap,
                        input int stall, input logic [16:0] es, input logic eo);
    int t;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!bus17.in_ready && t < 20) begin
        tick();
        t++;
      end
      chk({name, "_in_ready"}, bus17.in_ready, 1);
      bus17.in_valid = 1'b1;
      bus17.in_data  = v[i];
      tick();
      bus17.in_valid = 1'b0;
      if (i < 3) repeat (gap) tick();
    end
    chk({name, "_latency_valid"}, bus17.sum_valid, 1);
    chk({name, "_sum"}, bus17.sum_data, es);
    chk({name, "_ovf"}, bus17.sum_ovf, eo);
    if (stall > 0) begin
      bus17.sum_ready = 1'b0;
      bus17.in_valid  = 1'b1;
      bus17.in_data   = 16'($urandom);
      for (int k = 0; k < stall; k++) begin
        tick();
        chk({name, "_stall_sum"}, bus17.sum_data, es);
        chk({name, "_stall_in_ready"}, bus17.in_ready, 0);
      end
      bus17.sum_ready = 1'b1;
      bus17.in_valid  = 1'b0;
    end
    tick();
    exp_done17++;
    chk({name, "_blocks_done"}, done17, exp_done17[15:0]);
    chk({name, "_ovf_after"}, bus17.sum_ovf, 0);
  endtask

  initial begin
    tbl[0] = '{v: {16'd40, 16'd30, 16'd20, 16'd10}, gap: 0, stall: 0, es: 24'd100, eo: 1'b0};
    tbl[1] = '{v: {16'd0, 16'd0, 16'd0, 16'd0}, gap: 0, stall: 0, es: 24'd0, eo: 1'b0};
    tbl[2] = '{v: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, gap: 0, stall: 0, es: 24'h3FFFC, eo: 1'b0};
    tbl[3] = '{v: {16'd3, 16'd3, 16'd3, 16'd3}, gap: 2, stall: 0, es: 24'd12, eo: 1'b0};
    tbl[4] = '{v: {16'd400, 16'd300, 16'd200, 16'd100}, gap: 0, stall: 5, es: 24'd1000, eo: 1'b0};
    tbl[5] = '{v: {16'd1, 16'd1, 16'd1, 16'd1}, gap: 0, stall: 0, es: 24'd4, eo: 1'b0};

    clear0 = 1'b0; clear17 = 1'b0; clear1 = 1'b0;
    bus0.in_valid = 1'b0;  bus0.in_data = '0;  bus0.sum_ready = 1'b1;
    bus17.in_valid = 1'b0; bus17.in_data = '0; bus17.sum_ready = 1'b1;
    bus1.in_valid = 1'b0;  bus1.in_data = '0;  bus1.sum_ready = 1'b1;

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    chk("reset_in_ready", bus0.in_ready, 1);
    chk("reset_sum_valid", bus0.sum_valid, 0);
    chk("reset_sum_data", bus0.sum_data, 0);
    chk("reset_sum_ovf", bus0.sum_ovf, 0);
    chk("reset_blocks_done", done0, 0);

    for (int i = 0; i < 6; i++) begin
      send0($sformatf("tbl%0d", i), tbl[i].v, tbl[i].gap, tbl[i].stall, tbl[i].es, tbl[i].eo);
    end

    // clear mid-block: beat in the clear cycle is dropped, count restarts
    beat0(16'd5, 0);
    beat0(16'd7, 0);
    clear0 = 1'b1;
    bus0.in_valid = 1'b1;
    bus0.in_data  = 16'd9;
    tick();
    clear0 = 1'b0;
    bus0.in_valid = 1'b0;
    chk("clear_mid_valid", bus0.sum_valid, 0);
    chk("clear_mid_in_ready", bus0.in_ready, 1);
    chk("clear_mid_done", done0, exp_done0[15:0]);
    send0("after_clear", {16'd4, 16'd3, 16'd2, 16'd1}, 0, 0, 24'd10, 1'b0);

    // clear in HOLD wins over a simultaneous handshake
    for (int i = 0; i < 4; i++) beat0(16'd50, 0);
    chk("clear_hold_pre_valid", bus0.sum_valid, 1);
    clear0 = 1'b1;
    tick();
    clear0 = 1'b0;
    chk("clear_hold_valid", bus0.sum_valid, 0);
    chk("clear_hold_sum_zero", bus0.sum_data, 0);
    chk("clear_hold_done", done0, exp_done0[15:0]);
    tick();
    chk("clear_hold_done_later", done0, exp_done0[15:0]);

    // saturation at ACC_WIDTH = 17, with the exact-max boundary
    send17("sat_ffff", {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 0, 0, MAX17, 1'b1);
    send17("sat_next", {16'd1, 16'd1, 16'd1, 16'd1}, 0, 0, 17'd4, 1'b0);
    send17("exact_max", {16'd0, 16'd1, 16'hFFFF, 16'hFFFF}, 0, 0, MAX17, 1'b0);
    send17("max_plus1", {16'd0, 16'd2, 16'hFFFF, 16'hFFFF}, 0, 1, MAX17, 1'b1);

    // randomized blocks against a plain-arithmetic model
    for (int b = 0; b < 40; b++) begin : rnd
      logic [3:0][15:0] v;
      longint           tot;
      logic [16:0]      es;
      logic             eo;
      int               r;
      tot = 0;
      for (int i = 0; i < 4; i++) begin
        r = int'($urandom_range(0, 3));
        if (r == 0)      v[i] = 16'hFFFF;
        else if (r == 1) v[i] = 16'($urandom_range(30000, 65535));
        else             v[i] = 16'($urandom_range(0, 200));
        tot += longint'(v[i]);
      end
      eo = (tot > longint'(MAX17));
      es = eo ? MAX17 : 17'(tot);
      send17($sformatf("rnd%0d", b), v, int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)), es, eo);
    end

    // BLOCK_LEN = 1: every beat is a whole block
    chk("b1_in_ready", bus1.in_ready, 1);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 16'hABCD;
    tick();
    chk("b1_valid", bus1.sum_valid, 1);
    chk("b1_sum", bus1.sum_data, 32'hABCD);
    chk("b1_in_ready_hold", bus1.in_ready, 0);
    bus1.in_data = 16'h1234;
    tick();
    chk("b1_done1", done1, 1);
    chk("b1_in_ready_back", bus1.in_ready, 1);
    tick();
    bus1.in_valid = 1'b0;
    chk("b1_sum2", bus1.sum_data, 32'h1234);
    tick();
    chk("b1_done2", done1, 2);

    // asynchronous reset in the middle of a block
    beat0(16'd10, 0);
    beat0(16'd20, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_done", done0, 0);
    chk("rst_async_valid", bus0.sum_valid, 0);
    chk("rst_async_done17", done17, 0);
    #2 rst_n = 1'b1;
    exp_done0 = 0;
    exp_done17 = 0;
    tick();
    chk("rst_release_in_ready", bus0.in_ready, 1);
    send0("after_reset", {16'd40, 16'd30, 16'd20, 16'd10}, 0, 0, 24'd100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
